squeeze_kernal_loader: RTL and testbench
========================================

# squeeze_kernal_loader

Fetches squeeze-layer kernel weights from external memory over an Avalon-MM burst read master and streams them as 64-bit words into the squeeze kernel FIFO write port. It sits directly upstream of the squeeze kernel controller, drives its `fifo_squeeze_*` inputs and throttles itself on the FIFO data count, so the FIFO never overflows. One load runs per `start_i`, covering the whole weight block for a layer.

## Interface
- FIFO_DEPTH, 256: depth of the downstream squeeze FIFO, in 64-bit words.
- BURST_LEN, 16: maximum Avalon burst length, in words; power of two, ≤ 16.
- FIFO_MARGIN, 4: headroom words kept free to cover count and write-path lag.
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle pulse; begins a load. Ignored while `busy_o` = 1.
- base_addr_i  in  32  byte address of the first word; 8-byte aligned. Sampled on `start_i`.
- tot_words_i  in  16  number of 64-bit words to load. Sampled on `start_i`. A value of 0 is legal.
- busy_o  out  1  high from the cycle after an accepted start until `done_o`.
- done_o  out  1  one-cycle pulse when the last word has been written to the FIFO.
- fifo_squeeze_clr_o  out  1  one-cycle FIFO clear, issued at load start.
- fifo_squeeze_wr_data_o  out  64  FIFO write data.
- fifo_squeeze_wr_en_o  out  1  FIFO write strobe.
- fifo_squeeze_data_count_i  in  8  current FIFO fill level.
- avm_address_o  out  32  burst start byte address.
- avm_read_o  out  1  read request.
- avm_burstcount_o  out  5  burst length in words.
- avm_waitrequest_i  in  1  slave stall.
- avm_readdata_i  in  64  read data.
- avm_readdatavalid_i  in  1  read data valid.

## Operation
- State machine: IDLE, CLR, REQ, DRAIN, DONE.
- IDLE: on `start_i`:
  - latch `addr` = `base_addr_i` and `remaining` = `tot_words_i`;
  - go to CLR.
- CLR: assert `fifo_squeeze_clr_o` for exactly 1 cycle, then go to REQ.
- REQ with `remaining` = 0: go to DRAIN.
- REQ otherwise: compute `blen` = min(BURST_LEN, `remaining`).
  - Issue condition: `fifo_squeeze_data_count_i` + `outstanding` + `blen` ≤ FIFO_DEPTH − FIFO_MARGIN.
  - Arithmetic is 17-bit; no truncation.
  - When the condition holds, assert `avm_read_o` with `avm_address_o` = `addr` and `avm_burstcount_o` = `blen`.
  - Address, burstcount and read stay stable until a cycle with `avm_waitrequest_i` = 0.
  - On acceptance: `addr` += `blen`×8 (32-bit, wraps modulo 2^32), `remaining` −= `blen`, `outstanding` += `blen`.
  - Stay in REQ.
- `outstanding` is a 9-bit counter. It is decremented on every `avm_readdatavalid_i`.
  - Simultaneous burst accept and data beat: net change is +`blen` − 1.
- DRAIN: when `outstanding` = 0 and no write is pending in the output register, go to DONE.
- DONE: pulse `done_o` for 1 cycle, then go to IDLE.
- Write path:
  - `fifo_squeeze_wr_data_o` ← `avm_readdata_i` and `fifo_squeeze_wr_en_o` ← `avm_readdatavalid_i`, both registered.
  - Data is never dropped or reordered.
- A `start_i` pulse arriving in any non-IDLE state, including the DONE cycle, is ignored.
- Reset mid-load: every state, counter and output returns to its reset value immediately. Bus beats still in flight are discarded because the FIFO is cleared on the next start.

## Timing
- Reset values:
  - state = IDLE;
  - `busy_o`, `done_o`, `fifo_squeeze_clr_o`, `fifo_squeeze_wr_en_o`, `avm_read_o` = 0;
  - `avm_address_o` and `fifo_squeeze_wr_data_o` = 0;
  - `avm_burstcount_o` = 0;
  - `outstanding` = 0.
- `start_i` at cycle T: `busy_o` and `fifo_squeeze_clr_o` are high at T+1; the first `avm_read_o` can appear at T+2.
- Bus-to-FIFO latency: a beat with `avm_readdatavalid_i` at cycle N is written with `fifo_squeeze_wr_en_o` at N+1.
- Completion: last FIFO write at cycle N; `done_o` = 1 at N+1 at the latest; `busy_o` drops in the same cycle as `done_o`.
- `tot_words_i` = 0: CLR at T+1, `done_o` no later than T+4, no bus traffic.
- All outputs are registered.

## Structure
- Shared package `squeeze_pkg` holds:
  - the state enum encoding;
  - FIFO_DEPTH and FIFO_MARGIN defaults;
  - the 64-bit word width constant, shared with the squeeze kernel controller.
- Natural sub-module: `avm_burst_credit`. It owns the `outstanding` counter and the issue-condition compare.
- The FSM, address and remaining-count registers, and the write register stay in the top level.

## Test plan
- Basic load: `tot_words_i` = 40, `base_addr_i` = 0x1000, no waitrequest, zero-latency slave.
  - Required: bursts 16/16/8 at addresses 0x1000, 0x1080, 0x1100.
  - Required: 40 FIFO writes in order, then one `done_o` pulse.
- Backpressure: FIFO count held at 240 with FIFO_DEPTH = 256.
  - Required: no `avm_read_o` is asserted.
  - Releasing the count to 200 gives exactly one 16-word burst issued.
- Waitrequest: `avm_waitrequest_i` = 1 for 5 cycles on the first burst.
  - Required: address and burstcount are stable throughout, and the command is accepted once at cycle 6.
- Edge cases:
  - `tot_words_i` = 0 gives one clear pulse, then `done_o`, with zero bus reads.
  - `tot_words_i` = 17 gives bursts of 16 then 1.
- Simultaneous events: a burst is accepted in the same cycle as a data beat.
  - Required: `outstanding` goes 16 → 31, tracked by the bench model.
  - Extra `start_i` pulses while busy are ignored.
- Reset mid-load: `rst_n_i` low after 10 words.
  - Required: all outputs are 0 within the reset cycle.
  - A new `start_i` produces a clear and a complete, correct reload.

Source files
------------

// File: rtl/squeeze_pkg.sv
// Shared definitions for the squeeze kernel path: loader FSM encoding and FIFO geometry.
package squeeze_pkg;

    localparam int WORD_W          = 64;
    localparam int FIFO_DEPTH_DEF  = 256;
    localparam int FIFO_MARGIN_DEF = 4;
    localparam int BURST_LEN_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_REQ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/squeeze_kernal_loader_if.sv
// Avalon-MM burst read bus plus squeeze kernel FIFO write port, as seen by the loader.
interface squeeze_kernal_loader_if;
    import squeeze_pkg::*;

    logic [31:0]       avm_address_o;
    logic              avm_read_o;
    logic [4:0]        avm_burstcount_o;
    logic              avm_waitrequest_i;
    logic [WORD_W-1:0] avm_readdata_i;
    logic              avm_readdatavalid_i;

    logic              fifo_squeeze_clr_o;
    logic [WORD_W-1:0] fifo_squeeze_wr_data_o;
    logic              fifo_squeeze_wr_en_o;
    logic [7:0]        fifo_squeeze_data_count_i;

    modport master (
        output avm_address_o, avm_read_o, avm_burstcount_o,
        input  avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i,
        output fifo_squeeze_clr_o, fifo_squeeze_wr_data_o, fifo_squeeze_wr_en_o,
        input  fifo_squeeze_data_count_i
    );

    modport slave (
        input  avm_address_o, avm_read_o, avm_burstcount_o,
        output avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i,
        input  fifo_squeeze_clr_o, fifo_squeeze_wr_data_o, fifo_squeeze_wr_en_o,
        output fifo_squeeze_data_count_i
    );

endinterface

// File: rtl/squeeze_kernal_loader_avm_burst_credit.sv
// Tracks words requested but not yet returned, and decides whether another burst fits in the FIFO.
module avm_burst_credit #(
    parameter int FIFO_DEPTH  = 256,
    parameter int FIFO_MARGIN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] fifo_count,
    input  logic [4:0] blen,
    input  logic       accept,
    input  logic [4:0] accept_len,
    input  logic       beat,
    output logic [8:0] outstanding,
    output logic       can_issue
);

    localparam logic [16:0] LIMIT = 17'(FIFO_DEPTH - FIFO_MARGIN);

    logic [16:0] demand;

    // Widened to 17 bits so fill + in-flight + new burst can never wrap.
    assign demand    = 17'(fifo_count) + 17'(outstanding) + 17'(blen);
    assign can_issue = (demand <= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + (accept ? {4'b0, accept_len} : 9'd0) - {8'b0, beat};
        end
    end

endmodule

// File: rtl/squeeze_kernal_loader.sv
// Burst-reads a layer's squeeze kernel weights over Avalon-MM and writes them into the squeeze FIFO.
module squeeze_kernal_loader
    import squeeze_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int FIFO_MARGIN = FIFO_MARGIN_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [31:0]            base_addr_i,
    input  logic [15:0]            tot_words_i,
    output logic                   busy_o,
    output logic                   done_o,
    squeeze_kernal_loader_if.master bus
);

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic [15:0] remaining;
    logic [4:0]  blen;
    logic [8:0]  outstanding;
    logic        can_issue;
    logic        accept;
    logic        issue;

    assign blen   = (remaining >= 16'(BURST_LEN)) ? 5'(BURST_LEN) : remaining[4:0];
    assign accept = bus.avm_read_o && !bus.avm_waitrequest_i;
    // A new command is only formed once the previous one has retired, so addr/remaining are current.
    assign issue  = ((state == ST_CLR) || (state == ST_REQ)) && !bus.avm_read_o &&
                    (remaining != 16'd0) && can_issue;

    avm_burst_credit #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FIFO_MARGIN (FIFO_MARGIN)
    ) u_credit (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .fifo_count  (bus.fifo_squeeze_data_count_i),
        .blen        (blen),
        .accept      (accept),
        .accept_len  (bus.avm_burstcount_o),
        .beat        (bus.avm_readdatavalid_i),
        .outstanding (outstanding),
        .can_issue   (can_issue)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = ST_CLR;
            ST_CLR:   state_nxt = ST_REQ;
            ST_REQ:   if (remaining == 16'd0) state_nxt = ST_DRAIN;
            // With nothing in flight and no beat arriving, the write register holds the last word at most.
            ST_DRAIN: if ((outstanding == 9'd0) && !bus.avm_readdatavalid_i) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_o                 <= 1'b0;
            done_o                 <= 1'b0;
            bus.fifo_squeeze_clr_o <= 1'b0;
            addr                   <= '0;
            remaining              <= '0;
            bus.avm_read_o         <= 1'b0;
            bus.avm_address_o      <= '0;
            bus.avm_burstcount_o   <= '0;
        end else begin
            busy_o                 <= (state_nxt == ST_CLR) || (state_nxt == ST_REQ) ||
                                      (state_nxt == ST_DRAIN);
            done_o                 <= (state_nxt == ST_DONE);
            bus.fifo_squeeze_clr_o <= (state_nxt == ST_CLR);

            if ((state == ST_IDLE) && start_i) begin
                addr      <= base_addr_i;
                remaining <= tot_words_i;
            end else if (accept) begin
                addr      <= addr + {24'b0, bus.avm_burstcount_o, 3'b000};
                remaining <= remaining - 16'(bus.avm_burstcount_o);
            end

            if (accept) begin
                bus.avm_read_o <= 1'b0;
            end else if (issue) begin
                bus.avm_read_o       <= 1'b1;
                bus.avm_address_o    <= addr;
                bus.avm_burstcount_o <= blen;
            end
        end
    end

    // ---- write stage: one register between bus return and FIFO port ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.fifo_squeeze_wr_en_o   <= 1'b0;
            bus.fifo_squeeze_wr_data_o <= '0;
        end else begin
            bus.fifo_squeeze_wr_en_o   <= bus.avm_readdatavalid_i;
            bus.fifo_squeeze_wr_data_o <= bus.avm_readdata_i;
        end
    end

endmodule

// File: tb/tb_squeeze_kernal_loader.sv
// Directed bench for squeeze_kernal_loader with a behavioural Avalon burst slave.
module tb_squeeze_kernal_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [15:0] tot = '0;
    logic        busy, done;

    squeeze_kernal_loader_if bus ();

    squeeze_kernal_loader dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .base_addr_i (base),
        .tot_words_i (tot),
        .busy_o      (busy),
        .done_o      (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; int n; }   burst_t;
    typedef struct { logic [31:0] a; int rdy; } beat_t;

    int n_cmp = 0, n_fail = 0;
    int lat = 1, hold = 0;
    int ncyc = 0, read_cycles = 0, clr_cnt = 0, done_cnt = 0, last_wr_cyc = 0, done_cyc = 0;
    int w0, b0, c0, d0, r0;
    logic [63:0] wr_q[$];
    burst_t      burst_q[$];
    beat_t       beat_q[$];

    function automatic logic [63:0] word_of(input logic [31:0] a);
        return {~a, a};
    endfunction

    // Slave + monitor: observes outputs at negedge and drives slave inputs for the next edge.
    initial begin : slave
        burst_t b;
        beat_t  bt;
        int     wait_used;
        wait_used = 0;
        bus.avm_waitrequest_i   = 1'b0;
        bus.avm_readdatavalid_i = 1'b0;
        bus.avm_readdata_i      = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                beat_q.delete();
                wait_used = 0;
                bus.avm_waitrequest_i   = 1'b0;
                bus.avm_readdatavalid_i = 1'b0;
            end else begin
                if (bus.fifo_squeeze_wr_en_o) begin
                    wr_q.push_back(bus.fifo_squeeze_wr_data_o);
                    last_wr_cyc = ncyc;
                end
                if (bus.fifo_squeeze_clr_o) clr_cnt++;
                if (done) begin done_cnt++; done_cyc = ncyc; end
                if (bus.avm_read_o) read_cycles++;
                if (!bus.avm_read_o) wait_used = 0;
                if (bus.avm_read_o && wait_used < hold) begin
                    bus.avm_waitrequest_i = 1'b1;
                    wait_used++;
                end else begin
                    bus.avm_waitrequest_i = 1'b0;
                end
                if (bus.avm_read_o && !bus.avm_waitrequest_i) begin
                    b.a = bus.avm_address_o;
                    b.n = int'(bus.avm_burstcount_o);
                    burst_q.push_back(b);
                    for (int i = 0; i < b.n; i++) begin
                        bt.a   = b.a + 32'(8 * i);
                        bt.rdy = ncyc + lat;
                        beat_q.push_back(bt);
                    end
                end
                if (beat_q.size() > 0 && beat_q[0].rdy <= ncyc) begin
                    bus.avm_readdatavalid_i = 1'b1;
                    bus.avm_readdata_i      = word_of(beat_q[0].a);
                    void'(beat_q.pop_front());
                end else begin
                    bus.avm_readdatavalid_i = 1'b0;
                end
            end
        end
    end

    task automatic snap();
        w0 = wr_q.size(); b0 = burst_q.size(); c0 = clr_cnt; d0 = done_cnt; r0 = read_cycles;
    endtask

    task automatic start_load(input logic [31:0] a, input logic [15:0] n);
        @(negedge clk);
        base = a; tot = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit seen);
        seen = 1'b0; cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; cycles = i; return; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, bus.fifo_squeeze_clr_o, bus.fifo_squeeze_wr_en_o, bus.avm_read_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/clr/wr_en/read=%b want 00000",
                     {busy, done, bus.fifo_squeeze_clr_o, bus.fifo_squeeze_wr_en_o, bus.avm_read_o});
        end
        n_cmp++;
        if (bus.avm_address_o !== 32'h0 || bus.avm_burstcount_o !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_cmd: addr=%h bc=%0d want 0/0", bus.avm_address_o, bus.avm_burstcount_o);
        end
        n_cmp++;
        if (bus.fifo_squeeze_wr_data_o !== 64'h0) begin
            n_fail++; $display("FAIL reset_wr_data: got %h want 0", bus.fifo_squeeze_wr_data_o);
        end
        n_cmp++;
        if (dut.u_credit.outstanding !== 9'd0) begin
            n_fail++; $display("FAIL reset_outstanding: got %0d want 0", dut.u_credit.outstanding);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int cyc; bit seen;
        snap(); lat = 1; bus.fifo_squeeze_data_count_i = 8'd0;
        start_load(32'h1000, 16'd40);
        n_cmp++;
        if (busy !== 1'b1 || bus.fifo_squeeze_clr_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_t1: busy=%b clr=%b want 1/1", busy, bus.fifo_squeeze_clr_o);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.avm_read_o !== 1'b1) begin n_fail++; $display("FAIL basic_first_read_t2: read=%b want 1", bus.avm_read_o); end
        wait_done(300, cyc, seen);
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL basic_done: no done within 300 cycles, want pulse"); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: busy=%b want 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (burst_q.size() - b0 !== 3) begin
            n_fail++; $display("FAIL basic_burst_cnt: got %0d want 3", burst_q.size() - b0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (burst_q[b0+i].a !== 32'h1000 + 32'(i * 128) || burst_q[b0+i].n != ((i < 2) ? 16 : 8)) begin
                    n_fail++;
                    $display("FAIL basic_burst%0d: addr=%h len=%0d want %h/%0d", i, burst_q[b0+i].a,
                             burst_q[b0+i].n, 32'h1000 + 32'(i * 128), (i < 2) ? 16 : 8);
                end
            end
        end
        n_cmp++;
        if (wr_q.size() - w0 !== 40) begin
            n_fail++; $display("FAIL basic_wr_cnt: got %0d want 40", wr_q.size() - w0);
        end else begin
            for (int i = 0; i < 40; i++) begin
                n_cmp++;
                if (wr_q[w0+i] !== word_of(32'h1000 + 32'(8 * i))) begin
                    n_fail++; $display("FAIL basic_wr%0d: got %h want %h", i, wr_q[w0+i], word_of(32'h1000 + 32'(8 * i)));
                end
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 1 || clr_cnt - c0 !== 1) begin
            n_fail++; $display("FAIL basic_pulses: done=%0d clr=%0d want 1/1", done_cnt - d0, clr_cnt - c0);
        end
        n_cmp++;
        if (done_cyc - last_wr_cyc !== 1) begin
            n_fail++; $display("FAIL basic_done_latency: got %0d want 1", done_cyc - last_wr_cyc);
        end
    endtask

    task automatic test_backpressure();
        int cyc; bit seen;
        snap(); lat = 1;
        bus.fifo_squeeze_data_count_i = 8'd240;
        start_load(32'h7000, 16'd16);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (read_cycles - r0 !== 0) begin n_fail++; $display("FAIL bp_240_read: %0d read cycles want 0", read_cycles - r0); end
        bus.fifo_squeeze_data_count_i = 8'd237;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (read_cycles - r0 !== 0) begin n_fail++; $display("FAIL bp_237_read: %0d read cycles want 0", read_cycles - r0); end
        bus.fifo_squeeze_data_count_i = 8'd200;
        wait_done(100, cyc, seen);
        repeat (2) @(negedge clk);
        bus.fifo_squeeze_data_count_i = 8'd0;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL bp_done: no done within 100 cycles, want pulse"); end
        n_cmp++;
        if (burst_q.size() - b0 !== 1 || burst_q[burst_q.size()-1].n != 16 || burst_q[burst_q.size()-1].a !== 32'h7000) begin
            n_fail++; $display("FAIL bp_one_burst: bursts=%0d want 1 of 16 at 7000", burst_q.size() - b0);
        end
        n_cmp++;
        if (wr_q.size() - w0 !== 16) begin n_fail++; $display("FAIL bp_wr_cnt: got %0d want 16", wr_q.size() - w0); end
    endtask

    task automatic test_waitrequest();
        int cyc, cnt; bit seen, stable;
        logic [31:0] a0; logic [4:0] bc0;
        snap(); lat = 1; hold = 5;
        start_load(32'h2000, 16'd16);
        for (int i = 0; i < 20 && bus.avm_read_o !== 1'b1; i++) @(negedge clk);
        a0 = bus.avm_address_o; bc0 = bus.avm_burstcount_o; cnt = 0; stable = 1'b1;
        while (bus.avm_read_o === 1'b1 && cnt < 20) begin
            cnt++;
            if (bus.avm_address_o !== a0 || bus.avm_burstcount_o !== bc0) stable = 1'b0;
            @(negedge clk);
        end
        hold = 0;
        n_cmp++;
        if (cnt != 6) begin n_fail++; $display("FAIL wait_read_cycles: got %0d want 6", cnt); end
        n_cmp++;
        if (!stable || a0 !== 32'h2000 || bc0 !== 5'd16) begin
            n_fail++; $display("FAIL wait_cmd_stable: stable=%b addr=%h bc=%0d want 1/2000/16", stable, a0, bc0);
        end
        wait_done(100, cyc, seen);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!seen || burst_q.size() - b0 !== 1 || wr_q.size() - w0 !== 16) begin
            n_fail++; $display("FAIL wait_complete: done=%b bursts=%0d writes=%0d want 1/1/16", seen,
                               burst_q.size() - b0, wr_q.size() - w0);
        end
    endtask

    task automatic test_zero();
        int cyc; bit seen;
        snap();
        start_load(32'h6000, 16'd0);
        n_cmp++;
        if (bus.fifo_squeeze_clr_o !== 1'b1) begin n_fail++; $display("FAIL zero_clr: got %b want 1", bus.fifo_squeeze_clr_o); end
        wait_done(3, cyc, seen);
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL zero_done: no done by T+4, want pulse"); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (read_cycles - r0 !== 0 || clr_cnt - c0 !== 1 || done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL zero_traffic: reads=%0d clr=%0d done=%0d want 0/1/1", read_cycles - r0,
                               clr_cnt - c0, done_cnt - d0);
        end
    endtask

    task automatic test_17();
        int cyc; bit seen;
        logic [31:0] a;
        snap(); lat = 1;
        start_load(32'hFFFF_FFC0, 16'd17);
        wait_done(200, cyc, seen);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!seen || burst_q.size() - b0 !== 2) begin
            n_fail++; $display("FAIL w17_bursts: done=%b bursts=%0d want 1/2", seen, burst_q.size() - b0);
        end else begin
            n_cmp++;
            if (burst_q[b0].n != 16 || burst_q[b0+1].n != 1 || burst_q[b0+1].a !== 32'h0000_0040) begin
                n_fail++; $display("FAIL w17_lens: %0d/%0d at %h want 16/1 at 00000040", burst_q[b0].n,
                                   burst_q[b0+1].n, burst_q[b0+1].a);
            end
        end
        n_cmp++;
        if (wr_q.size() - w0 !== 17) begin
            n_fail++; $display("FAIL w17_wr_cnt: got %0d want 17", wr_q.size() - w0);
        end else begin
            a = 32'hFFFF_FFC0 + 32'd128;
            n_cmp++;
            if (wr_q[w0+16] !== word_of(a)) begin n_fail++; $display("FAIL w17_last: got %h want %h", wr_q[w0+16], word_of(a)); end
        end
    endtask

    task automatic test_simul();
        int ov[$]; logic [8:0] prev; bit seen, ok;
        snap(); lat = 2; seen = 1'b0;
        start_load(32'h3000, 16'd32);
        prev = dut.u_credit.outstanding;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (dut.u_credit.outstanding !== prev) begin prev = dut.u_credit.outstanding; ov.push_back(int'(prev)); end
            base = 32'hDEAD_0000; tot = 16'd5;
            start = (i == 4 || i == 15);
            if (done === 1'b1) begin seen = 1'b1; start = 1'b1; end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        lat = 1;
        n_cmp++;
        if (ov.size() < 2 || ov[0] != 16 || ov[1] != 31) begin
            n_fail++; $display("FAIL simul_outstanding: first=%0d second=%0d want 16/31",
                               (ov.size() > 0) ? ov[0] : -1, (ov.size() > 1) ? ov[1] : -1);
        end
        n_cmp++;
        if (!seen || busy !== 1'b0 || clr_cnt - c0 !== 1 || done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL simul_extra_start: done=%b busy=%b clr=%0d dones=%0d want 1/0/1/1", seen, busy,
                               clr_cnt - c0, done_cnt - d0);
        end
        ok = (wr_q.size() - w0 == 32) && (burst_q.size() - b0 == 2);
        if (ok) for (int i = 0; i < 32; i++) if (wr_q[w0+i] !== word_of(32'h3000 + 32'(8 * i))) ok = 1'b0;
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL simul_data: writes=%0d bursts=%0d want 32 ordered/2", wr_q.size() - w0, burst_q.size() - b0); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen, ok;
        snap(); lat = 1;
        start_load(32'h4000, 16'd40);
        for (int i = 0; i < 200 && (wr_q.size() - w0) < 10; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, bus.fifo_squeeze_clr_o, bus.fifo_squeeze_wr_en_o, bus.avm_read_o} !== 5'b0 ||
            bus.avm_address_o !== 32'h0 || bus.fifo_squeeze_wr_data_o !== 64'h0 ||
            bus.avm_burstcount_o !== 5'h0 || dut.u_credit.outstanding !== 9'd0) begin
            n_fail++; $display("FAIL midreset_outputs: ctrl=%b addr=%h bc=%0d outst=%0d want all 0",
                               {busy, done, bus.fifo_squeeze_clr_o, bus.fifo_squeeze_wr_en_o, bus.avm_read_o},
                               bus.avm_address_o, bus.avm_burstcount_o, dut.u_credit.outstanding);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        snap();
        start_load(32'h5000, 16'd20);
        n_cmp++;
        if (bus.fifo_squeeze_clr_o !== 1'b1) begin n_fail++; $display("FAIL reload_clr: got %b want 1", bus.fifo_squeeze_clr_o); end
        wait_done(200, cyc, seen);
        repeat (2) @(negedge clk);
        ok = seen && (wr_q.size() - w0 == 20) && (burst_q.size() - b0 == 2);
        if (ok) for (int i = 0; i < 20; i++) if (wr_q[w0+i] !== word_of(32'h5000 + 32'(8 * i))) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL reload_data: done=%b writes=%0d bursts=%0d want 1/20 ordered/2", seen,
                               wr_q.size() - w0, burst_q.size() - b0);
        end
    endtask

    initial begin : main
        bus.fifo_squeeze_data_count_i = 8'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_waitrequest();
        test_zero();
        test_17();
        test_simul();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
